// File: rtl/counter_pkg.sv
// Shared constants and step-direction encoding for the cascaded modulo-N counter.
package counter_pkg;

  localparam int DEF_DIGITS  = 4;
  localparam int DEF_MODULUS = 10;
  localparam int DEF_WIDTH   = 4;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } step_dir_e;

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-N digit register: clear > load (with clamping) > step.
module mod_n_digit
  import counter_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  step_dir_e        dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_digit,
  output logic [WIDTH-1:0] value,
  output logic             is_max,
  output logic             is_zero,
  output logic             clamp
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Extra MSB keeps the compare meaningful when MODULUS == 2**WIDTH.
  assign clamp   = ({1'b0, load_digit} >= MOD_EXT);
  assign is_max  = (value_q == MAX_VAL);
  assign is_zero = (value_q == '0);
  assign value   = value_q;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      value_d = clamp ? MAX_VAL : load_digit;
    end else if (step_en) begin
      case (dir)
        UP:      value_d = is_max  ? '0      : value_q + WIDTH'(1);
        DOWN:    value_d = is_zero ? MAX_VAL : value_q - WIDTH'(1);
        default: value_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/mod_n_digit_counter.sv
// Cascaded modulo-N up/down counter with clear, clamped load and registered wrap flags.
module mod_n_digit_counter
  import counter_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_val,
  output logic [DIGITS*WIDTH-1:0] count,
  output logic                    carry_out,
  output logic                    borrow_out,
  output logic                    load_err,
  output logic                    at_zero,
  output logic                    at_max
);

  step_dir_e        dir;
  logic [DIGITS-1:0] step_en;
  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] clamp;
  logic [WIDTH-1:0]  digit_value [DIGITS];

  logic carry_q, carry_d;
  logic borrow_q, borrow_d;
  logic load_err_q, load_err_d;

  always_comb begin
    dir = HOLD;
    if (inc && !dec) begin
      dir = UP;
    end else if (dec && !inc) begin
      dir = DOWN;
    end
  end

  // Ripple enable: a digit steps only when every lower digit is at its wrap point.
  assign step_en[0] = (dir != HOLD);

  genvar gi;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_chain
      assign step_en[gi] = step_en[gi-1] &
                           ((dir == UP) ? is_max[gi-1] : is_zero[gi-1]);
    end

    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      mod_n_digit #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
      ) u_digit (
        .clk        (clk),
        .rst        (rst),
        .step_en    (step_en[gi]),
        .dir        (dir),
        .clear      (clear),
        .load       (load),
        .load_digit (load_val[gi*WIDTH +: WIDTH]),
        .value      (digit_value[gi]),
        .is_max     (is_max[gi]),
        .is_zero    (is_zero[gi]),
        .clamp      (clamp[gi])
      );
      assign count[gi*WIDTH +: WIDTH] = digit_value[gi];
    end
  endgenerate

  assign at_zero = &is_zero;
  assign at_max  = &is_max;

  // Flags only fire for the operation that actually wins this cycle.
  always_comb begin
    carry_d    = !clear && !load && (dir == UP)   && at_max;
    borrow_d   = !clear && !load && (dir == DOWN) && at_zero;
    load_err_d = !clear && load && (|clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Directed tests plus a full up-count sweep against an integer model for the 4-digit decimal counter.
module tb_mod_n_digit_counter;

  localparam int DIGITS  = 4;
  localparam int MODULUS = 10;
  localparam int WIDTH   = 4;

  logic                    clk;
  logic                    rst;
  logic                    inc;
  logic                    dec;
  logic                    clear;
  logic                    load;
  logic [DIGITS*WIDTH-1:0] load_val;
  logic [DIGITS*WIDTH-1:0] count;
  logic                    carry_out;
  logic                    borrow_out;
  logic                    load_err;
  logic                    at_zero;
  logic                    at_max;

  int checks;
  int failures;

  mod_n_digit_counter #(
    .DIGITS  (DIGITS),
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .dec        (dec),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .carry_out  (carry_out),
    .borrow_out (borrow_out),
    .load_err   (load_err),
    .at_zero    (at_zero),
    .at_max     (at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inc = 1'b1;
    tick(); tick();
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL reset_count got %h want 0000", count); end
    checks++; if (at_zero !== 1'b1) begin failures++; $display("FAIL reset_at_zero got %b want 1", at_zero); end
    checks++; if (at_max !== 1'b0) begin failures++; $display("FAIL reset_at_max got %b want 0", at_max); end
    checks++; if ({carry_out, borrow_out, load_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {carry_out, borrow_out, load_err}); end
    $display("reset: count=%h at_zero=%b", count, at_zero);
    rst = 1'b0;
    tick();
    inc = 1'b0;
    checks++; if (count !== 16'h0001) begin failures++; $display("FAIL first_step got %h want 0001", count); end
    $display("first inc: count=%h", count);
  endtask

  task automatic test_carry();
    do_load(16'h0999);
    inc = 1'b1; tick(); inc = 1'b0;
    checks++; if (count !== 16'h1000) begin failures++; $display("FAIL ripple_up got %h want 1000", count); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL ripple_no_carry got %b want 0", carry_out); end
    $display("0999+1: count=%h carry=%b", count, carry_out);
    do_load(16'h9999);
    checks++; if (at_max !== 1'b1) begin failures++; $display("FAIL load_max_at_max got %b want 1", at_max); end
    inc = 1'b1; tick(); inc = 1'b0;
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL wrap_up got %h want 0000", count); end
    checks++; if (carry_out !== 1'b1) begin failures++; $display("FAIL carry_pulse got %b want 1", carry_out); end
    checks++; if (at_zero !== 1'b1) begin failures++; $display("FAIL wrap_at_zero got %b want 1", at_zero); end
    $display("9999+1: count=%h carry=%b", count, carry_out);
    tick();
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL carry_one_cycle got %b want 0", carry_out); end
    $display("hold after wrap: count=%h carry=%b", count, carry_out);
  endtask

  task automatic test_borrow();
    do_load(16'h0000);
    dec = 1'b1; tick();
    checks++; if (count !== 16'h9999) begin failures++; $display("FAIL wrap_down got %h want 9999", count); end
    checks++; if (borrow_out !== 1'b1) begin failures++; $display("FAIL borrow_pulse got %b want 1", borrow_out); end
    checks++; if (at_max !== 1'b1) begin failures++; $display("FAIL borrow_at_max got %b want 1", at_max); end
    $display("0000-1: count=%h borrow=%b", count, borrow_out);
    tick(); dec = 1'b0;
    checks++; if (count !== 16'h9998) begin failures++; $display("FAIL second_dec got %h want 9998", count); end
    checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL borrow_one_cycle got %b want 0", borrow_out); end
    $display("9999-1: count=%h borrow=%b", count, borrow_out);
    do_load(16'h1000);
    dec = 1'b1; tick(); dec = 1'b0;
    checks++; if (count !== 16'h0999) begin failures++; $display("FAIL ripple_down got %h want 0999", count); end
    $display("1000-1: count=%h", count);
  endtask

  task automatic test_load_clamp();
    load = 1'b1; inc = 1'b1; load_val = 16'hC3F5;
    tick();
    load = 1'b0; inc = 1'b0;
    checks++; if (count !== 16'h9395) begin failures++; $display("FAIL clamp_count got %h want 9395", count); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL load_err_pulse got %b want 1", load_err); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL load_no_carry got %b want 0", carry_out); end
    $display("load C3F5: count=%h load_err=%b", count, load_err);
    tick();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL load_err_one_cycle got %b want 0", load_err); end
    checks++; if (count !== 16'h9395) begin failures++; $display("FAIL clamp_hold got %h want 9395", count); end
    do_load(16'h0705);
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL legal_load_err got %b want 0", load_err); end
    checks++; if (count !== 16'h0705) begin failures++; $display("FAIL legal_load got %h want 0705", count); end
    $display("load 0705: count=%h load_err=%b", count, load_err);
  endtask

  task automatic test_hold_clear();
    do_load(16'h0042);
    inc = 1'b1; dec = 1'b1; tick(); inc = 1'b0; dec = 1'b0;
    checks++; if (count !== 16'h0042) begin failures++; $display("FAIL both_hold got %h want 0042", count); end
    checks++; if ({carry_out, borrow_out} !== 2'b00) begin failures++; $display("FAIL hold_flags got %b want 00", {carry_out, borrow_out}); end
    $display("inc&dec: count=%h", count);
    clear = 1'b1; load = 1'b1; load_val = 16'hFFFF; tick(); clear = 1'b0; load = 1'b0;
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL clear_over_load got %h want 0000", count); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL clear_no_load_err got %b want 0", load_err); end
    $display("clear&load: count=%h load_err=%b", count, load_err);
    do_load(16'h9999);
    clear = 1'b1; inc = 1'b1; tick(); clear = 1'b0; inc = 1'b0;
    checks++; if ({count, carry_out} !== {16'h0000, 1'b0}) begin failures++; $display("FAIL clear_suppress_carry got %h/%b want 0000/0", count, carry_out); end
    do_load(16'h0000);
    rst = 1'b1; dec = 1'b1; tick(); rst = 1'b0; dec = 1'b0;
    checks++; if ({count, borrow_out} !== {16'h0000, 1'b0}) begin failures++; $display("FAIL rst_suppress_borrow got %h/%b want 0000/0", count, borrow_out); end
    $display("clear/rst over wrap: count=%h carry=%b borrow=%b", count, carry_out, borrow_out);
  endtask

  task automatic test_back_to_back();
    int model;
    int pulses;
    int sweep_fail;
    logic [15:0] exp;
    model = 0; pulses = 0; sweep_fail = 0;
    do_load(16'h0000);
    inc = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      tick();
      model = (model + 1) % 10000;
      exp = to_bcd(model);
      if (carry_out === 1'b1) pulses++;
      checks++;
      if ({count, carry_out} !== {exp, (model == 0)}) begin
        failures++; sweep_fail++;
        if (sweep_fail <= 5) $display("FAIL sweep step %0d got %h/%b want %h/%b", n, count, carry_out, exp, (model == 0));
      end
    end
    inc = 1'b0;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL sweep_carry_count got %0d want 1", pulses); end
    $display("sweep 10000 incs: count=%h carry pulses=%0d", count, pulses);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; inc = 1'b0; dec = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    #1;
    test_reset();
    test_carry();
    test_borrow();
    test_load_clamp();
    test_hold_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
